// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
//
// Instruction-memory responder for the fetch side of the core. Fetch requests
// arrive as byte addresses over a valid/ready channel and read a word-addressed
// instruction RAM. Each response carries the instruction, the echoed PC and an
// error flag, and is returned strictly in order through a 2-entry buffer. A
// side write port preloads and patches the program memory.
//
// Ports:
//   i_clock      rising-edge clock
//   i_resetn     asynchronous active-low reset
//   i_req_valid  fetch request valid
//   o_req_ready  responder can accept a request this cycle (combinational)
//   i_req_addr   fetch byte address (PC)
//   o_rsp_valid  response valid
//   i_rsp_ready  consumer accepts the response this cycle
//   o_rsp_instr  fetched instruction, or NOP_INSTR on error
//   o_rsp_pc     address of the request this response answers
//   o_rsp_err    1 = misaligned or out-of-range request
//   i_wr_en      memory write strobe
//   i_wr_addr    write byte address (word index = addr[31:2])
//   i_wr_data    write data
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_instr,
  output logic [31:0] o_rsp_pc,
  output logic        o_rsp_err,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int          IDXW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  // Program memory and the 2-entry response buffer storage (neither is reset)
  logic [31:0] mem_q       [MEM_WORDS];
  logic [31:0] fifoInstr_q [2];
  logic [31:0] fifoPc_q    [2];
  logic        fifoErr_q   [2];

  // Buffer bookkeeping; count_q is the number of outstanding requests
  logic [1:0]  count_q, count_d;
  logic        rdPtr_q, rdPtr_d;
  logic        wrPtr_q, wrPtr_d;

  // Registered copy of the buffer head, which drives the response outputs
  logic        rspValid_q, rspValid_d;
  logic [31:0] rspInstr_q, rspInstr_d;
  logic [31:0] rspPc_q, rspPc_d;
  logic        rspErr_q, rspErr_d;

  logic            pop, push, reqErr, wrInRange, headIsNew;
  logic [31:0]     reqInstr;
  logic [IDXW-1:0] reqIdx, wrIdx;

  // Byte-offset bits of the write address carry no information for a word RAM
  logic unusedWrLow;
  assign unusedWrLow = ^i_wr_addr[1:0];

  assign o_rsp_valid = rspValid_q;
  assign o_rsp_instr = rspInstr_q;
  assign o_rsp_pc    = rspPc_q;
  assign o_rsp_err   = rspErr_q;

  // Handshake decode, request classification and next-state for the buffer.
  // The head register is loaded with the incoming response directly when the
  // buffer would otherwise be empty, which gives single-cycle latency; when
  // the buffer drains the head register simply keeps its last contents.
  always_comb begin
    reqIdx    = i_req_addr[IDXW+1:2];
    wrIdx     = i_wr_addr[IDXW+1:2];
    reqErr    = (i_req_addr[1:0] != 2'b00) ||
                ({2'b00, i_req_addr[31:2]} >= MEM_WORDS_W);
    wrInRange = {2'b00, i_wr_addr[31:2]} < MEM_WORDS_W;
    reqInstr  = reqErr ? NOP_INSTR : mem_q[reqIdx];

    pop         = rspValid_q && i_rsp_ready;
    o_req_ready = i_resetn && ((count_q != 2'd2) || pop);
    push        = i_req_valid && o_req_ready;

    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    rdPtr_d   = rdPtr_q ^ pop;
    wrPtr_d   = wrPtr_q ^ push;
    headIsNew = push && (count_q == {1'b0, pop});
    rspValid_d = (count_d != 2'd0);

    rspInstr_d = rspInstr_q;
    rspPc_d    = rspPc_q;
    rspErr_d   = rspErr_q;
    if (headIsNew) begin
      rspInstr_d = reqInstr;
      rspPc_d    = i_req_addr;
      rspErr_d   = reqErr;
    end else if (rspValid_d) begin
      rspInstr_d = fifoInstr_q[rdPtr_d];
      rspPc_d    = fifoPc_q[rdPtr_d];
      rspErr_d   = fifoErr_q[rdPtr_d];
    end
  end

  // Control state and response head; everything here is cleared by reset so
  // that buffered responses are discarded.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      count_q    <= 2'd0;
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
      rspValid_q <= 1'b0;
      rspInstr_q <= 32'd0;
      rspPc_q    <= 32'd0;
      rspErr_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      rspValid_q <= rspValid_d;
      rspInstr_q <= rspInstr_d;
      rspPc_q    <= rspPc_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // Memory writes and buffer captures. The read for an accepted request uses
  // the memory value before this edge's write, so a same-word collision
  // returns the old data.
  always_ff @(posedge i_clock) begin
    if (i_wr_en && wrInRange) begin
      mem_q[wrIdx] <= i_wr_data;
    end
    if (push) begin
      fifoInstr_q[wrPtr_q] <= reqInstr;
      fifoPc_q[wrPtr_q]    <= i_req_addr;
      fifoErr_q[wrPtr_q]   <= reqErr;
    end
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder serving fetch requests from the PC/fetch side of the core. Accepts byte addresses over a valid/ready request channel and reads a word-addressed synchronous instruction RAM. Returns instruction plus echoed PC over a valid/ready response channel, strictly in order, with up to 2 responses buffered. A side write port preloads and patches program memory.

Parameters:
MEM_WORDS, 256, instruction memory depth in 32-bit words; word index = addr[31:2]
NOP_INSTR, 32'h0000_0013, instruction returned on error responses (ADDI x0,x0,0)

Ports:
i_clock  input  1  clock, rising edge
i_resetn  input  1  reset, asynchronous, active-low
i_req_valid  input  1  fetch request valid
o_req_ready  output  1  responder can accept request this cycle
i_req_addr  input  32  fetch byte address (PC)
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  consumer accepts response this cycle
o_rsp_instr  output  32  fetched instruction, or NOP_INSTR on error
o_rsp_pc  output  32  address of the request this response answers
o_rsp_err  output  1  1 = misaligned or out-of-range request
i_wr_en  input  1  memory write strobe
i_wr_addr  input  32  write byte address; word index = addr[31:2], addr[1:0] ignored
i_wr_data  input  32  write data

Behaviour:
- Reset (async assert, sync-to-clock release): o_rsp_valid=0, o_rsp_instr=0, o_rsp_pc=0, o_rsp_err=0, outstanding count=0, buffer pointers=0. o_req_ready=0 while i_resetn=0; =1 in the first cycle after release. Memory contents are not reset.
- Reset mid-operation: all in-flight and buffered responses are discarded; none appear after release.
- Request handshake: accepted on a rising edge where i_req_valid && o_req_ready. i_req_addr is sampled only at that edge.
- Outstanding count OUT (0..2) = accepted requests whose responses are not yet consumed. o_req_ready = (OUT<2) || (o_rsp_valid && i_rsp_ready), purely combinational. This gives one-per-cycle throughput when the consumer is always ready.
- OUT update: +1 on request accept, -1 on response handshake, unchanged if both or neither occur.
- Latency: request accepted at edge E produces a response visible from the cycle after E, i.e. o_rsp_valid=1 one cycle after acceptance when the buffer is empty.
- Read: a synchronous RAM read is performed at the accept edge. Response data is captured into a 2-entry in-order FIFO holding {instr, pc, err}; outputs are driven from the FIFO head.
- Response handshake: the head is popped at an edge where o_rsp_valid && i_rsp_ready. While o_rsp_valid=1 and i_rsp_ready=0, o_rsp_instr, o_rsp_pc and o_rsp_err hold stable.
- Empty FIFO: o_rsp_valid=0, and the data outputs hold their last values.
- Full: the FIFO never overflows because OUT<=2. A request accepted when OUT=2 is legal only in the same cycle as a pop.
- Error, misaligned: i_req_addr[1:0]!=0 sets err=1 and instr=NOP_INSTR.
- Error, out of range: addr[31:2] >= MEM_WORDS sets err=1 and instr=NOP_INSTR.
- Error responses obey the same ordering and latency as normal responses. The pc field always echoes the full request address.
- Write port: when i_wr_en=1 at an edge, mem[i_wr_addr[31:2]] <= i_wr_data. Out-of-range writes are ignored.
- Write/read collision: if a write and a request accept hit the same word at the same edge, the response returns the OLD data (read-before-write). Later requests see the new data.
- Writes are independent of the handshakes and are allowed while responses are stalled. An already-captured response is never altered by a later write.

Test Plan:
- Preload mem[0..3]=32'hA0..A3. Issue requests 0x0, 0x4, 0x8, 0xC back-to-back with i_rsp_ready=1. Required: o_rsp_valid from the cycle after the first accept, 4 consecutive responses instr=A0..A3 with pc 0,4,8,C, err=0, o_req_ready stays 1.
- Backpressure: i_rsp_ready=0 with requests 0x0, 0x4, 0x8 offered continuously. Required: first two accepted, o_req_ready=0 afterwards, o_rsp_instr=A0 held stable. Raise i_rsp_ready: A0, A1, A2 delivered in order with no loss or duplicate, and 0x8 accepted in the first pop cycle.
- Errors: request 0x2. Required: err=1, instr=32'h0000_0013, pc=0x2. Request 0x400 with MEM_WORDS=256. Required: err=1, NOP_INSTR, pc=0x400.
- Collision: mem[1]=A1, then write 32'hDEAD_BEEF to 0x4 on the same edge as accepting request 0x4. Required: response A1. A following request to 0x4 returns DEAD_BEEF.
- Reset mid-operation: two responses buffered with i_rsp_ready=0, then pulse i_resetn low asynchronously between edges. Required: o_rsp_valid=0 immediately, all outputs 0, o_req_ready=0 during reset and 1 after release, no stale responses afterwards, memory contents retained.
- Random: random valid/ready stalls over 1000 requests. Required: responses match a scoreboard model in order, OUT never exceeds 2, data stable under stall.
